mem_access_stage: RTL

//  MEM pipeline stage, directly downstream of the EX/MEM register. Consumes its *_MEM outputs.

---
 rtl/mem_access_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/ack port, stalls upstream while an
// access is pending, resolves PCSrc and registers the MEM/WB results.
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] PC_next_MEM,
  input  logic [DATA_W-1:0] ALU_result_MEM,
  input  logic [DATA_W-1:0] Read_Data_2_MEM,
  input  logic              Branch_MEM,
  input  logic              Zero_MEM,
  input  logic              Jump_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              MemToReg_MEM,
  input  logic              RegWrite_MEM,
  input  logic [REG_W-1:0]  Write_register_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              PCSrc_MEM,
  output logic [DATA_W-1:0] PC_target,
  output logic [DATA_W-1:0] Read_Data_WB,
  output logic [DATA_W-1:0] ALU_result_WB,
  output logic              MemToReg_WB,
  output logic              RegWrite_WB,
  output logic [REG_W-1:0]  Write_register_WB,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             access_s, stall_s, start_s, ack_s, abort_s;

  assign access_s  = MemRead_MEM | MemWrite_MEM;
  // Reset forces stall low so the pipeline is released while the stage is held in reset.
  assign stall     = stall_s & rst_n;
  assign PCSrc_MEM = (Jump_MEM | (Branch_MEM & Zero_MEM)) & ~stall;
  assign PC_target = PC_next_MEM;

  // Next-state and per-cycle control decode.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    start_s      = 1'b0;
    ack_s        = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          stall_s      = 1'b1;
          start_s      = 1'b1;
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          ack_s        = 1'b1;
          next_state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          abort_s      = 1'b1;
          next_state_s = IDLE;
        end else begin
          stall_s      = 1'b1;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, timeout counter and memory-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= {DATA_W{1'b0}};
      dmem_wdata <= {DATA_W{1'b0}};
      mem_err    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      mem_err <= mem_err | abort_s;
      if (start_s) begin
        cnt_r      <= '0;
        dmem_req   <= 1'b1;
        dmem_we    <= MemWrite_MEM;
        dmem_addr  <= ALU_result_MEM;
        dmem_wdata <= Read_Data_2_MEM;
      end else if (ack_s || abort_s) begin
        dmem_req <= 1'b0;
      end else if (state_r == ACCESS) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // MEM/WB register: stalled and aborted instructions retire as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Read_Data_WB      <= {DATA_W{1'b0}};
      ALU_result_WB     <= {DATA_W{1'b0}};
      MemToReg_WB       <= 1'b0;
      RegWrite_WB       <= 1'b0;
      Write_register_WB <= {REG_W{1'b0}};
    end else if (stall_s) begin
      MemToReg_WB <= 1'b0;
      RegWrite_WB <= 1'b0;
    end else begin
      ALU_result_WB     <= ALU_result_MEM;
      Write_register_WB <= Write_register_MEM;
      MemToReg_WB       <= abort_s ? 1'b0 : MemToReg_MEM;
      RegWrite_WB       <= abort_s ? 1'b0 : RegWrite_MEM;
      Read_Data_WB      <= (ack_s && !dmem_we) ? dmem_rdata : {DATA_W{1'b0}};
    end
  end

endmodule
